// File: rtl/sd_hs_pkg.sv
// Shared types and constants for the SD hardware/software PIO handshake.
// The two-bit codes match what NIOS reads from to_sw_sig and writes to to_hw_sig.
package sd_hs_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        ACK     = 3'd2,
        ERR     = 3'd3,
        ERR_CLR = 3'd4
    } state_e;

    // Hardware -> software status codes (to_sw_sig)
    localparam logic [1:0] SW_IDLE = 2'b00;
    localparam logic [1:0] SW_REQ  = 2'b01;
    localparam logic [1:0] SW_ACK  = 2'b10;
    localparam logic [1:0] SW_ERR  = 2'b11;

    // Software -> hardware command codes (to_hw_sig); 2'b11 is reserved
    localparam logic [1:0] HW_IDLE  = 2'b00;
    localparam logic [1:0] HW_DATA  = 2'b01;
    localparam logic [1:0] HW_ABORT = 2'b10;

    // Status code software sees for each state; ERR and ERR_CLR look identical.
    function automatic logic [1:0] sw_code(input state_e st);
        logic [1:0] code;
        case (st)
            REQ:     code = SW_REQ;
            ACK:     code = SW_ACK;
            ERR:     code = SW_ERR;
            ERR_CLR: code = SW_ERR;
            default: code = SW_IDLE;
        endcase
        return code;
    endfunction

    // Fold the reserved software code onto IDLE so the FSM only sees legal values.
    function automatic logic [1:0] hw_norm(input logic [1:0] sig);
        return (sig == 2'b11) ? HW_IDLE : sig;
    endfunction

endpackage

// File: rtl/sd_sync2.sv
// Two-flop synchroniser for a small bus of quasi-static control bits.
// Each bit is synchronised independently; callers must only use it for
// codes where a one-cycle skew between bits is harmless.
module sd_sync2 #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1_q, s1_d;
    logic [W-1:0] s2_q, s2_d;

    // Next values: the input shifts into s1, s1 shifts into s2.
    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    // Synchroniser flops; the first stage gets a full cycle to resolve.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/sd_hw_sw_handshake.sv
// Hardware side of the SD word-read handshake with NIOS software.
// A request from the SD data path is published on to_sw_sig/to_sw_addr; software
// answers through to_hw_sig/to_hw_data, and the word (or an error) is returned
// through a single-entry response register. Timeout and abort keep it from hanging.
module sd_hw_sw_handshake
    import sd_hs_pkg::*;
#(
    parameter int          ADDR_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 32'd50_000_000,
    parameter int          CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic              rsp_err,
    output logic [1:0]        to_sw_sig,
    output logic [ADDR_W-1:0] to_sw_addr,
    input  logic [1:0]        to_hw_sig,
    input  logic [31:0]       to_hw_data,
    output logic [CNT_W-1:0]  xfer_count
);

    // Timer only has to reach TIMEOUT_CYC-1.
    localparam int TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMR_W-1:0] TIMER_LAST =
        TMR_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [1:0]         to_sw_sig_q, to_sw_sig_d;
    logic [ADDR_W-1:0]  to_sw_addr_q, to_sw_addr_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q, rsp_err_d;
    logic [31:0]        rsp_data_q, rsp_data_d;
    logic [CNT_W-1:0]   xfer_count_q, xfer_count_d;

    logic [1:0]         hw_sig_s2;
    logic [1:0]         hw_sig;
    logic               accept;
    logic               timeout_hit;

    sd_sync2 #(
        .W (2)
    ) u_sync_hw_sig (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (to_hw_sig),
        .q       (hw_sig_s2)
    );

    assign hw_sig      = hw_norm(hw_sig_s2);
    assign req_ready   = (state_q == IDLE) && !rsp_valid_q;
    assign accept      = req_valid && req_ready;
    assign timeout_hit = (TIMEOUT_CYC != 0) && (timer_q == TIMER_LAST);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: software data beats abort, abort beats timeout.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = REQ;
            end
            REQ: begin
                if (hw_sig == HW_DATA)       state_d = ACK;
                else if (hw_sig == HW_ABORT) state_d = ERR;
                else if (timeout_hit)        state_d = ERR;
            end
            ACK: begin
                // Either IDLE or ABORT from software releases the acknowledge.
                if (hw_sig != HW_DATA) state_d = IDLE;
            end
            ERR: begin
                if (hw_sig == HW_ABORT) state_d = ERR_CLR;
            end
            ERR_CLR: begin
                if (hw_sig == HW_IDLE) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values, all registered so the PIO never sees glitches.
    always_comb begin
        timer_d      = timer_q;
        to_sw_addr_d = to_sw_addr_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_err_d    = rsp_err_q;
        rsp_data_d   = rsp_data_q;
        xfer_count_d = xfer_count_q;
        to_sw_sig_d  = sw_code(state_d);

        // Consumer pop; a new response in the same cycle overrides below.
        if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    to_sw_addr_d = req_addr;
                    timer_d      = '0;
                end
            end
            REQ: begin
                timer_d = timer_q + 1'b1;
                if (state_d == ACK) begin
                    // to_hw_data is stable while software holds DATA_VALID.
                    rsp_data_d   = to_hw_data;
                    rsp_err_d    = 1'b0;
                    rsp_valid_d  = 1'b1;
                    xfer_count_d = xfer_count_q + 1'b1;
                end else if (state_d == ERR) begin
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output, timer and response registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_q      <= '0;
            to_sw_sig_q  <= SW_IDLE;
            to_sw_addr_q <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_data_q   <= '0;
            xfer_count_q <= '0;
        end else begin
            timer_q      <= timer_d;
            to_sw_sig_q  <= to_sw_sig_d;
            to_sw_addr_q <= to_sw_addr_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_data_q   <= rsp_data_d;
            xfer_count_q <= xfer_count_d;
        end
    end

    assign to_sw_sig  = to_sw_sig_q;
    assign to_sw_addr = to_sw_addr_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_data   = rsp_data_q;
    assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_sd_hw_sw_handshake.sv
// Bench for sd_hw_sw_handshake. The bench plays the NIOS software role; a
// scoreboard queue collects expected responses and a negedge monitor checks
// each response as the consumer takes it.
module tb_sd_hw_sw_handshake;

    localparam int ADDR_W = 32;
    localparam int TO     = 16;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [31:0]       rsp_data;
    logic              rsp_err;
    logic [1:0]        to_sw_sig;
    logic [ADDR_W-1:0] to_sw_addr;
    logic [1:0]        to_hw_sig = 2'b00;
    logic [31:0]       to_hw_data = '0;
    logic [CNT_W-1:0]  xfer_count;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   rr_mode = 0;       // 0 random, 1 low, 2 high, 3 single pulse
    int   model_cnt = 0;     // successful transfers modulo 2^CNT_W

    always #5 clk = ~clk;

    sd_hw_sw_handshake #(
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TO),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .to_sw_sig  (to_sw_sig),
        .to_sw_addr (to_sw_addr),
        .to_hw_sig  (to_hw_sig),
        .to_hw_data (to_hw_data),
        .xfer_count (xfer_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Consumer ready driver, applied after the main thread has set the mode.
    always @(posedge clk) begin
        #2;
        case (rr_mode)
            0: rsp_ready = ($urandom_range(0, 2) != 0);
            1: rsp_ready = 1'b0;
            2: rsp_ready = 1'b1;
            default: begin
                rsp_ready = 1'b1;
                rr_mode   = 1;
            end
        endcase
    end

    // Monitor: a handshake set up before this negedge completes at the next posedge.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rsp_unexpected: got err=%0b data=%0h expected no response", rsp_err, rsp_data);
            end else begin
                e = exp_q.pop_front();
                check("sb_rsp_err", rsp_err, e.err);
                check("sb_rsp_data", rsp_data, e.data);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Issue a request and confirm it is published to software one edge later.
    task automatic issue_req(input logic [31:0] addr);
        bit ok;
        ok = 1'b0;
        req_valid = 1'b1;
        req_addr  = addr;
        for (int i = 0; i < 200; i++) begin
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("req_accept_wait", ok, 1'b1);
        tick();
        req_valid = 1'b0;
        check("req_sw_sig", to_sw_sig, 2'b01);
        check("req_sw_addr", to_sw_addr, addr);
    endtask

    // One full request. kind: 0 data, 1 abort, 2 silent, 3 reserved code.
    // Software drives its code k cycles after the accept edge; the FSM sees it
    // three edges later, and the timeout fires TO edges after accept.
    task automatic sw_transfer(input int kind, input int k, input logic [31:0] addr, input logic [31:0] d);
        int   ev;
        bit   is_data;
        exp_t e;
        logic [1:0] rel;
        issue_req(addr);
        if ((kind == 0 || kind == 1) && (k + 3 <= TO)) begin
            ev      = k + 3;
            is_data = (kind == 0);
        end else begin
            ev      = TO;
            is_data = 1'b0;
        end
        for (int n = 0; n < ev; n++) begin
            if (n == k) begin
                case (kind)
                    0: begin to_hw_data = d; to_hw_sig = 2'b01; end
                    1: to_hw_sig = 2'b10;
                    3: to_hw_sig = 2'b11;
                    default: ;
                endcase
            end
            if (n == ev - 1) begin
                check("req_hold_sig", to_sw_sig, 2'b01);
                check("req_ready_busy", req_ready, 1'b0);
            end
            tick();
        end
        if (is_data) begin
            model_cnt = (model_cnt + 1) % (1 << CNT_W);
            e.err = 1'b0;
            e.data = d;
            exp_q.push_back(e);
            check("ack_sig", to_sw_sig, 2'b10);
            check("ack_rsp_valid", rsp_valid, 1'b1);
            check("ack_rsp_err", rsp_err, 1'b0);
            check("ack_rsp_data", rsp_data, d);
        end else begin
            e.err = 1'b1;
            e.data = '0;
            exp_q.push_back(e);
            check("err_sig", to_sw_sig, 2'b11);
            check("err_rsp_valid", rsp_valid, 1'b1);
            check("err_rsp_err", rsp_err, 1'b1);
            check("err_rsp_data", rsp_data, 32'h0);
        end
        check("xfer_count", xfer_count, model_cnt);
        if (is_data) begin
            case ($urandom_range(0, 2))
                0:       rel = 2'b00;
                1:       rel = 2'b10;
                default: rel = 2'b11;
            endcase
            to_hw_sig = rel;
            tick(); tick();
            check("ack_release_hold", to_sw_sig, 2'b10);
            tick();
            check("ack_release_idle", to_sw_sig, 2'b00);
        end else begin
            to_hw_sig = 2'b10;
            tick(); tick(); tick();
            check("err_clr_sig", to_sw_sig, 2'b11);
            to_hw_sig = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
            tick(); tick();
            check("err_clr_hold", to_sw_sig, 2'b11);
            tick();
            check("err_clr_idle", to_sw_sig, 2'b00);
        end
        to_hw_sig = 2'b00;
        tick(); tick(); tick();
    endtask

    initial begin
        // Reset values while reset is held
        #12;
        check("rst_sig", to_sw_sig, 2'b00);
        check("rst_addr", to_sw_addr, '0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_rsp_data", rsp_data, 32'h0);
        check("rst_xfer_count", xfer_count, 0);
        check("rst_req_ready", req_ready, 1'b1);
        @(posedge clk);
        #3 reset_n = 1'b1;
        tick();

        // Normal read with the consumer holding off
        rr_mode = 1;
        sw_transfer(0, 2, 32'h0000_1234, 32'hDEAD_BEEF);

        // Back-pressure: the held response blocks new requests
        req_valid = 1'b1;
        req_addr  = 32'h0000_5678;
        repeat (4) begin
            tick();
            check("bp_req_ready_low", req_ready, 1'b0);
        end
        rr_mode = 3;
        tick();
        check("bp_req_ready_high", req_ready, 1'b1);
        sw_transfer(0, 4, 32'h0000_5678, 32'hCAFE_F00D);
        rr_mode = 0;

        // Timeout, abort, tie, one-late, reserved code
        sw_transfer(2, 0, $urandom, $urandom);
        sw_transfer(1, 3, $urandom, $urandom);
        sw_transfer(0, TO - 3, $urandom, $urandom);
        sw_transfer(0, TO - 2, $urandom, $urandom);
        sw_transfer(3, 2, $urandom, $urandom);

        // Residual DATA_VALID while idle is ignored
        to_hw_data = $urandom;
        to_hw_sig  = 2'b01;
        repeat (5) begin
            tick();
            check("idle_residual_sig", to_sw_sig, 2'b00);
            check("idle_residual_cnt", xfer_count, model_cnt);
        end
        to_hw_sig = 2'b00;
        tick(); tick(); tick();

        // Enough successful transfers to wrap the counter
        for (int i = 0; i < (1 << CNT_W) + 1; i++)
            sw_transfer(0, int'($urandom_range(0, 3)), $urandom, $urandom);

        // Randomized mix
        for (int i = 0; i < 40; i++)
            sw_transfer(int'($urandom_range(0, 3)), int'($urandom_range(0, TO)), $urandom, $urandom);

        // Asynchronous reset in the middle of a request
        issue_req(32'hABCD_0001);
        tick(); tick();
        #2 reset_n = 1'b0;
        #1;
        check("arst_sig", to_sw_sig, 2'b00);
        check("arst_rsp_valid", rsp_valid, 1'b0);
        check("arst_addr", to_sw_addr, '0);
        check("arst_xfer_count", xfer_count, 0);
        model_cnt = 0;
        exp_q.delete();
        @(posedge clk);
        #3 reset_n = 1'b1;
        tick();
        sw_transfer(0, 1, 32'h0000_0042, 32'h1234_5678);

        // Drain and confirm every expected response was consumed
        rr_mode = 2;
        repeat (4) tick();
        check("sb_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
